// File: rtl/lift_pkg.sv
// Shared types for the DWT lifting update stage.
// Mode/state enums and width extensions used by lift_update_stage.
package lift_pkg;

  typedef enum logic {
    LIFT_HAAR = 1'b0,
    LIFT_53   = 1'b1
  } lift_mode_e;

  typedef enum logic {
    ROW_START = 1'b0,
    ROW_RUN   = 1'b1
  } row_state_e;

  // Coefficient width is DATA_W + COEF_EXT; sums use DATA_W + SUM_EXT.
  localparam int COEF_EXT = 2;
  localparam int SUM_EXT  = 3;

endpackage

// File: rtl/lift_fifo.sv
// Synchronous FIFO for one input stream of the lifting update stage.
// Ports: push_i/data_i in, pop_i/data_o out, full_o/empty_o, drop_o.
module lift_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts when an entry leaves this cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/lift_update_stage.sv
// Lifting update stage: pairs even samples with details, emits coarse.
// In: mode, even_input/valid, detail_coefficient/valid. Out: coarse_*,
// row_end, overflow, sat_flag (only with LIFT_UPDATE_SAT_EN defined).
module lift_update_stage
  import lift_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ROW_LEN    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [DATA_W-1:0]          even_input,
  input  logic                       even_valid,
  input  logic [DATA_W:0]            detail_coefficient,
  input  logic                       detail_valid,
  output logic [DATA_W+COEF_EXT-1:0] coarse_coefficients,
  output logic                       coarse_valid,
  output logic                       row_end,
  output logic                       overflow
`ifdef LIFT_UPDATE_SAT_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int COEF_W = DATA_W + COEF_EXT;
  localparam int SUM_W  = DATA_W + SUM_EXT;
  localparam int IDX_W  = $clog2(ROW_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROW_LEN - 1);
  localparam logic signed [SUM_W-1:0] TWO = SUM_W'(2);

  logic [DATA_W-1:0] x_head;
  logic [DATA_W:0]   d_head;
  logic              e_empty;
  logic              d_empty;
  logic              e_full;
  logic              d_full;
  logic              e_drop;
  logic              d_drop;
  logic              pop;

  assign pop = ~e_empty & ~d_empty;

  lift_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_even_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (even_valid),
    .data_i  (even_input),
    .pop_i   (pop),
    .data_o  (x_head),
    .full_o  (e_full),
    .empty_o (e_empty),
    .drop_o  (e_drop)
  );

  lift_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_detail_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (detail_valid),
    .data_i  (detail_coefficient),
    .pop_i   (pop),
    .data_o  (d_head),
    .full_o  (d_full),
    .empty_o (d_empty),
    .drop_o  (d_drop)
  );

  logic unused_full;
  assign unused_full = e_full ^ d_full;

  row_state_e          state_q, state_d;
  lift_mode_e          mode_q, mode_d;
  lift_mode_e          mode_eff;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W:0]     dprev_q, dprev_d;
  logic [DATA_W:0]     dp_sel;
  logic                ovf_q, ovf_d;
  logic [COEF_W-1:0]   coef_q, coef_d;
  logic                cv_q, cv_d;
  logic                re_q, re_d;
  logic                sat_q, sat_d;

  // Row start uses live mode and its own detail (symmetric extension).
  assign mode_eff = (state_q == ROW_START) ? lift_mode_e'(mode) : mode_q;
  assign dp_sel   = (state_q == ROW_START) ? d_head : dprev_q;

  logic signed [SUM_W-1:0] x_s;
  logic signed [SUM_W-1:0] d_s;
  logic signed [SUM_W-1:0] dp_s;
  logic signed [SUM_W-1:0] haar_s;
  logic signed [SUM_W-1:0] l53_s;
  logic signed [SUM_W-1:0] sum_s;
  logic [COEF_W-1:0]       res;
  logic                    res_sat;

  assign x_s    = signed'({3'b000, x_head});
  assign d_s    = signed'({{2{d_head[DATA_W]}}, d_head});
  assign dp_s   = signed'({{2{dp_sel[DATA_W]}}, dp_sel});
  assign haar_s = d_s >>> 1;
  assign l53_s  = (dp_s + d_s + TWO) >>> 2;
  assign sum_s  = x_s + ((mode_eff == LIFT_53) ? l53_s : haar_s);

`ifdef LIFT_UPDATE_SAT_EN
  localparam logic [COEF_W-1:0] MAXV = {2'b00, {DATA_W{1'b1}}};

  always_comb begin
    res     = sum_s[COEF_W-1:0];
    res_sat = 1'b0;
    if (sum_s[SUM_W-1]) begin
      res     = '0;
      res_sat = 1'b1;
    end else if (|sum_s[SUM_W-2:DATA_W]) begin
      res     = MAXV;
      res_sat = 1'b1;
    end
  end
`else
  // Top sum bit is redundant: the result always fits COEF_W signed.
  logic unused_msb;
  assign unused_msb = sum_s[SUM_W-1];
  assign res        = sum_s[COEF_W-1:0];
  assign res_sat    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    dprev_d = dprev_q;
    coef_d  = coef_q;
    cv_d    = 1'b0;
    re_d    = 1'b0;
    sat_d   = 1'b0;
    ovf_d   = ovf_q | e_drop | d_drop;
    if (pop) begin
      cv_d    = 1'b1;
      coef_d  = res;
      sat_d   = res_sat;
      dprev_d = d_head;
      unique case (state_q)
        ROW_START: begin
          mode_d  = lift_mode_e'(mode);
          idx_d   = IDX_W'(1);
          state_d = ROW_RUN;
        end
        ROW_RUN: begin
          if (idx_q == LAST) begin
            re_d    = 1'b1;
            idx_d   = '0;
            state_d = ROW_START;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = ROW_START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ROW_START;
      mode_q  <= LIFT_HAAR;
      idx_q   <= '0;
      dprev_q <= '0;
      ovf_q   <= 1'b0;
      coef_q  <= '0;
      cv_q    <= 1'b0;
      re_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      dprev_q <= dprev_d;
      ovf_q   <= ovf_d;
      coef_q  <= coef_d;
      cv_q    <= cv_d;
      re_q    <= re_d;
      sat_q   <= sat_d;
    end
  end

  assign coarse_coefficients = coef_q;
  assign coarse_valid        = cv_q;
  assign row_end             = re_q;
  assign overflow            = ovf_q;

`ifdef LIFT_UPDATE_SAT_EN
  assign sat_flag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_lift_update_stage.sv
// Self-checking bench for lift_update_stage against a queue-based model.
// Honours LIFT_UPDATE_SAT_EN for clamp/sat_flag expectations.
module tb_lift_update_stage;

  localparam int DW    = 8;
  localparam int RL    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic [DW-1:0] even_input = '0;
  logic          even_valid = 1'b0;
  logic [DW:0]   detail_coefficient = '0;
  logic          detail_valid = 1'b0;
  logic [DW+1:0] coarse_coefficients;
  logic          coarse_valid;
  logic          row_end;
  logic          overflow;
`ifdef LIFT_UPDATE_SAT_EN
  logic          sat_flag;
`endif

  lift_update_stage #(
    .DATA_W     (DW),
    .ROW_LEN    (RL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mode                (mode),
    .even_input          (even_input),
    .even_valid          (even_valid),
    .detail_coefficient  (detail_coefficient),
    .detail_valid        (detail_valid),
    .coarse_coefficients (coarse_coefficients),
    .coarse_valid        (coarse_valid),
    .row_end             (row_end),
    .overflow            (overflow)
`ifdef LIFT_UPDATE_SAT_EN
    ,
    .sat_flag            (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int obs_v  = 0;

  int       eq[$];
  int       dq[$];
  int       row_i = 0;
  int       dprev = 0;
  bit       mode_l = 1'b0;
  bit       e_ovf = 1'b0;
  logic [DW+1:0] e_c = '0;
  bit       e_v = 1'b0;
  bit       e_re = 1'b0;
  bit       e_sat = 1'b0;

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit m, input bit ev,
                      input int x, input bit dv, input int d);
    int xx;
    int dd;
    int s;
    rst                = r;
    mode               = m;
    even_valid         = ev;
    even_input         = DW'(x);
    detail_valid       = dv;
    detail_coefficient = (DW+1)'(d);
    @(posedge clk);
    if (r) begin
      eq.delete();
      dq.delete();
      row_i = 0;
      dprev = 0;
      e_ovf = 1'b0;
      e_c   = '0;
      e_v   = 1'b0;
      e_re  = 1'b0;
      e_sat = 1'b0;
    end else begin
      e_v   = 1'b0;
      e_re  = 1'b0;
      e_sat = 1'b0;
      if (eq.size() > 0 && dq.size() > 0) begin
        xx = eq.pop_front();
        dd = dq.pop_front();
        if (row_i == 0) begin
          mode_l = m;
          dprev  = dd;
        end
        if (mode_l) s = xx + fdiv(dprev + dd + 2, 4);
        else        s = xx + fdiv(dd, 2);
`ifdef LIFT_UPDATE_SAT_EN
        if (s < 0) begin
          s = 0;
          e_sat = 1'b1;
        end else if (s > (1 << DW) - 1) begin
          s = (1 << DW) - 1;
          e_sat = 1'b1;
        end
`endif
        e_c   = (DW+2)'(s);
        e_v   = 1'b1;
        e_re  = (row_i == RL - 1);
        row_i = (row_i + 1) % RL;
        dprev = dd;
      end
      if (ev) begin
        if (eq.size() < DEPTH) eq.push_back(x);
        else e_ovf = 1'b1;
      end
      if (dv) begin
        if (dq.size() < DEPTH) dq.push_back(d);
        else e_ovf = 1'b1;
      end
    end
    #1;
    if (coarse_valid === 1'b1) obs_v++;
    check("coarse_valid", 16'(coarse_valid), 16'(e_v));
    check("coarse", 16'(coarse_coefficients), 16'(e_c));
    check("row_end", 16'(row_end), 16'(e_re));
    check("overflow", 16'(overflow), 16'(e_ovf));
`ifdef LIFT_UPDATE_SAT_EN
    check("sat_flag", 16'(sat_flag), 16'(e_sat));
`endif
  endtask

  task automatic idle(input int n, input bit m);
    for (int i = 0; i < n; i++) step(0, m, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_coarse", 16'(coarse_coefficients), 16'd0);

    // Haar, skewed arrival: detail first, even one cycle later.
    step(0, 0, 0, 0, 1, 40);
    step(0, 0, 1, 6, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("haar_26", 16'(coarse_coefficients), 16'd26);
    step(0, 0, 0, 0, 1, 81);
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("haar_43", 16'(coarse_coefficients), 16'd43);
    step(0, 0, 1, 10, 1, -5);
    step(0, 0, 0, 0, 0, 0);
    check("haar_neg", 16'(coarse_coefficients), 16'd7);
    step(0, 0, 1, 1, 1, 2);
    step(0, 0, 0, 0, 0, 0);
    check("haar_rowend", 16'(row_end), 16'd1);

    // LeGall 5/3 rows, mode flipped mid-row must be ignored.
    step(0, 1, 1, 6, 1, 40);
    step(0, 1, 0, 0, 0, 0);
    check("l53_ext", 16'(coarse_coefficients), 16'd26);
    step(0, 1, 1, 3, 1, 81);
    step(0, 0, 0, 0, 0, 0);
    check("l53_33", 16'(coarse_coefficients), 16'd33);
    step(0, 0, 1, 200, 1, -100);
    step(0, 0, 1, 17, 1, 255);
    idle(2, 1);
    step(0, 1, 1, 6, 1, 40);
    step(0, 0, 1, 3, 1, 81);
    check("l53_row2_ext", 16'(coarse_coefficients), 16'd26);
    step(0, 0, 1, 99, 1, -256);
    step(0, 0, 1, 0, 1, 0);
    idle(2, 0);

    // Skew/overflow: five evens, no details, then four details.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 10 + i, 0, 0);
    check("ovf_set", 16'(overflow), 16'd1);
    obs_v = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 2 * i - 3);
    idle(3, 0);
    check("ovf_outputs", 16'(obs_v), 16'd4);

    // Reset mid-row, then row restart with extension.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 50 + i, 1, i * 30);
    idle(1, 1);
    step(1, 1, 1, 77, 1, 77);
    check("mid_rst_coarse", 16'(coarse_coefficients), 16'd0);
    check("mid_rst_valid", 16'(coarse_valid), 16'd0);
    check("mid_rst_ovf", 16'(overflow), 16'd0);
    step(0, 1, 1, 6, 1, 40);
    step(0, 0, 0, 0, 0, 0);
    check("post_rst_ext", 16'(coarse_coefficients), 16'd26);
    idle(1, 0);

`ifdef LIFT_UPDATE_SAT_EN
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 250, 1, 255);
    step(0, 0, 1, 0, 1, -256);
    check("sat_hi", 16'(coarse_coefficients), 16'd255);
    check("sat_hi_flag", 16'(sat_flag), 16'd1);
    step(0, 0, 0, 0, 0, 0);
    check("sat_lo", 16'(coarse_coefficients), 16'd0);
    check("sat_lo_flag", 16'(sat_flag), 16'd1);
    idle(1, 0);
`endif

    // Sustained full-rate streaming.
    step(1, 0, 0, 0, 0, 0);
    obs_v = 0;
    for (int i = 0; i < 12; i++)
      step(0, 1, 1, $urandom_range(0, 255), 1,
           int'($urandom_range(0, 511)) - 256);
    check("full_rate", 16'(obs_v), 16'd11);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 255),
           $urandom_range(0, 9) < 7,
           int'($urandom_range(0, 511)) - 256);
    end
    idle(6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
